// File: rtl/light_sched_pkg.sv
// light_sched_pkg: sequencer states, approach indices and lamp/walk encodings
package light_sched_pkg;
    typedef enum logic [2:0] {IDLE, ARROW, GREEN, YELLOW, ALLRED} state_e;
    localparam logic [1:0] APP_N = 2'd0, APP_W = 2'd1, APP_E = 2'd2, APP_S = 2'd3;
    localparam int LAMP_BIT_RED = 0, LAMP_BIT_YEL = 1, LAMP_BIT_GRN = 2, LAMP_BIT_ARROW = 3;
    localparam logic [3:0] LAMP_RED = 4'b0001, LAMP_YEL = 4'b0010, LAMP_GRN = 4'b0100, LAMP_ARROW = 4'b1001;
    localparam logic [1:0] WALK_ON = 2'b10, WALK_OFF = 2'b01;
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational round-robin picker, searches ptr+1 .. ptr (mod 4)
module rr_pick4 (
    input  logic [3:0] elig,
    input  logic [1:0] ptr,
    output logic [1:0] grant_idx,
    output logic       grant_vld
);
    logic [1:0] cand;
    always_comb begin
        grant_idx = ptr;
        grant_vld = 1'b0;
        cand      = ptr;
        // walk farthest to nearest so the nearest eligible approach wins
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (elig[cand]) begin
                grant_idx = cand;
                grant_vld = 1'b1;
            end
        end
    end
endmodule

// File: rtl/light_phase_scheduler.sv
// light_phase_scheduler: round-robin green/yellow/all-red sequencer with pedestrian walk.
// Define LIGHT_SCHED_LEFT_ARROW_EN to enable the protected left-arrow phase.
module light_phase_scheduler
    import light_sched_pkg::*;
#(
    parameter int GREEN_TICKS     = 8,
    parameter int YELLOW_TICKS    = 3,
    parameter int ALLRED_TICKS    = 2,
    parameter int PED_FLASH_TICKS = 4,
    parameter int ARROW_TICKS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic [3:0] req,
    input  logic [3:0] ped_req,
    input  logic [3:0] left_req,
    output logic [3:0] N,
    output logic [3:0] W,
    output logic [3:0] E,
    output logic [3:0] S,
    output logic [1:0] N_walk,
    output logic [1:0] W_walk,
    output logic [1:0] E_walk,
    output logic [1:0] S_walk,
    output logic [1:0] phase,
    output logic       off_sign
);
    localparam int MAX_GY = GREEN_TICKS > YELLOW_TICKS ? GREEN_TICKS : YELLOW_TICKS;
    localparam int MAX_RA = ALLRED_TICKS > ARROW_TICKS ? ALLRED_TICKS : ARROW_TICKS;
    localparam int MAX_D  = MAX_GY > MAX_RA ? MAX_GY : MAX_RA;
    localparam int TW     = $clog2(MAX_D) + 1;
    localparam logic [TW-1:0] T_ONE   = TW'(1);
    localparam logic [TW-1:0] T_FLASH = TW'(PED_FLASH_TICKS);
`ifdef LIGHT_SCHED_LEFT_ARROW_EN
    localparam logic [3:0] ARROW_LAMP = LAMP_ARROW;
`else
    localparam logic [3:0] ARROW_LAMP = LAMP_RED;
`endif

    state_e          state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;
    logic [1:0]      ptr, ptr_nxt, phase_nxt, grant_idx;
    logic [3:0]      veh_pend, ped_pend, pend_clr, elig;
    logic            walk_act, walk_act_nxt, grant_vld, pick;
    logic [3:0][3:0] lamp_q, lamp_nxt;
    logic [3:0][1:0] walk_q, walk_nxt;

`ifdef LIGHT_SCHED_LEFT_ARROW_EN
    logic [3:0] left_pend, arrow_clr;
    assign elig = veh_pend | ped_pend | left_pend;
    always_ff @(posedge clk or posedge rst)
        if (rst) left_pend <= '0;
        else     left_pend <= (left_pend | left_req) & ~arrow_clr;
`else
    logic unused_left;
    assign unused_left = ^left_req;
    assign elig = veh_pend | ped_pend;
`endif

    rr_pick4 u_pick (
        .elig      (elig),
        .ptr       (ptr),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    always_comb begin
        state_nxt    = state;
        timer_nxt    = (tick && state != IDLE) ? timer - T_ONE : timer;
        ptr_nxt      = ptr;
        phase_nxt    = phase;
        walk_act_nxt = walk_act;
        pend_clr     = '0;
        lamp_nxt     = '0;
        walk_nxt     = '0;
`ifdef LIGHT_SCHED_LEFT_ARROW_EN
        arrow_clr    = '0;
`endif
        pick = tick && (state == IDLE || (state == ALLRED && timer == T_ONE));
        if (pick) begin
            ptr_nxt   = grant_vld ? grant_idx : ptr;
            phase_nxt = grant_vld ? grant_idx : phase;
            state_nxt = grant_vld ? GREEN : IDLE;
`ifdef LIGHT_SCHED_LEFT_ARROW_EN
            if (grant_vld && left_pend[grant_idx]) state_nxt = ARROW;
`endif
        end else if (tick && timer == T_ONE)
            state_nxt = state == ARROW ? GREEN : state == GREEN ? YELLOW : ALLRED;
        if (state_nxt != state)
            timer_nxt = state_nxt == ARROW  ? TW'(ARROW_TICKS)  :
                        state_nxt == GREEN  ? TW'(GREEN_TICKS)  :
                        state_nxt == YELLOW ? TW'(YELLOW_TICKS) :
                        state_nxt == ALLRED ? TW'(ALLRED_TICKS) : '0;
        // walk is decided by the pedestrian latch as it stood when green began
        if (state_nxt == GREEN && state != GREEN) begin
            pend_clr[ptr_nxt] = 1'b1;
            walk_act_nxt      = ped_pend[ptr_nxt];
        end
`ifdef LIGHT_SCHED_LEFT_ARROW_EN
        if (state_nxt == ARROW && state != ARROW) arrow_clr[ptr_nxt] = 1'b1;
`endif
        for (int j = 0; j < 4; j++) begin
            lamp_nxt[j] = ptr_nxt != 2'(j)     ? LAMP_RED   :
                          state_nxt == ARROW   ? ARROW_LAMP :
                          state_nxt == GREEN   ? LAMP_GRN   :
                          state_nxt == YELLOW  ? LAMP_YEL   : LAMP_RED;
            walk_nxt[j] = (ptr_nxt == 2'(j) && state_nxt == GREEN && walk_act_nxt) ?
                          (timer_nxt > T_FLASH ? WALK_ON : {T_FLASH[0] ^ timer_nxt[0], 1'b0}) :
                          WALK_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            ptr      <= APP_S;
            phase    <= APP_N;
            walk_act <= 1'b0;
            veh_pend <= '0;
            ped_pend <= '0;
            lamp_q   <= {4{LAMP_RED}};
            walk_q   <= {4{WALK_OFF}};
            off_sign <= 1'b1;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            ptr      <= ptr_nxt;
            phase    <= phase_nxt;
            walk_act <= walk_act_nxt;
            veh_pend <= (veh_pend | req) & ~pend_clr;
            ped_pend <= (ped_pend | ped_req) & ~pend_clr;
            lamp_q   <= lamp_nxt;
            walk_q   <= walk_nxt;
            off_sign <= state_nxt == IDLE;
        end

    assign N      = lamp_q[APP_N];
    assign W      = lamp_q[APP_W];
    assign E      = lamp_q[APP_E];
    assign S      = lamp_q[APP_S];
    assign N_walk = walk_q[APP_N];
    assign W_walk = walk_q[APP_W];
    assign E_walk = walk_q[APP_E];
    assign S_walk = walk_q[APP_S];
endmodule

// File: tb/tb_light_phase_scheduler.sv
// tb_light_phase_scheduler: directed checks of grant order, lamp spans, walk flash and async reset
module tb_light_phase_scheduler;
    logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [3:0] req = '0, ped_req = '0, left_req = '0;
    logic [3:0] N, W, E, S;
    logic [1:0] N_walk, W_walk, E_walk, S_walk, phase;
    logic       off_sign;
    logic [15:0] lamps;
    logic [7:0]  walks;
    int checks = 0, failures = 0;

    localparam logic [15:0] ALL_RED  = 16'h1111;
    localparam logic [7:0]  WALK_DEF = 8'h55;

    assign lamps = {S, E, W, N};
    assign walks = {S_walk, E_walk, W_walk, N_walk};

    light_phase_scheduler dut (
        .clk(clk), .rst(rst), .tick(tick), .req(req), .ped_req(ped_req), .left_req(left_req),
        .N(N), .W(W), .E(E), .S(S),
        .N_walk(N_walk), .W_walk(W_walk), .E_walk(E_walk), .S_walk(S_walk),
        .phase(phase), .off_sign(off_sign)
    );

    always #5 clk = ~clk;

    initial forever begin
        repeat (3) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] lit(input int a, input logic [3:0] v);
        logic [15:0] r;
        r = ALL_RED;
        r[a*4 +: 4] = v;
        return r;
    endfunction

    task automatic next_tick;
        do @(posedge clk); while (!tick);
        #1;
    endtask

    task automatic span(input string tag, input logic [15:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, lamps, exp);
            next_tick();
        end
    endtask

    task automatic pulse(input logic [3:0] v, input logic [3:0] p, input logic [3:0] l);
        req = v; ped_req = p; left_req = l;
        @(posedge clk);
        #1;
        req = '0; ped_req = '0; left_req = '0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        next_tick();
    endtask

    initial begin
        logic [1:0] wseq [8];
        wseq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_lamps", lamps, ALL_RED);
        check("rst_walk", walks, WALK_DEF);
        check("rst_off", off_sign, 1);
        check("rst_phase", phase, 0);
        repeat (3) next_tick();
        check("idle_lamps", lamps, ALL_RED);
        check("idle_off", off_sign, 1);

        pulse(4'b0010, 4'b0000, 4'b0000);
        next_tick();
        check("w_phase", phase, 1);
        check("w_off", off_sign, 0);
        span("w_grn", lit(1, 4'b0100), 8);
        span("w_yel", lit(1, 4'b0010), 3);
        span("w_ar", ALL_RED, 2);
        check("w_idle_off", off_sign, 1);
        check("w_idle_lamps", lamps, ALL_RED);

        do_reset();
        pulse(4'b1111, 4'b0000, 4'b0000);
        next_tick();
        for (int a = 0; a < 4; a++) begin
            check("rr_phase", phase, a);
            span("rr_grn", lit(a, 4'b0100), 8);
            span("rr_yel", lit(a, 4'b0010), 3);
            span("rr_ar", ALL_RED, 2);
        end
        check("rr_idle_off", off_sign, 1);

        do_reset();
        pulse(4'b0000, 4'b0001, 4'b0000);
        next_tick();
        for (int i = 0; i < 8; i++) begin
            check("ped_grn", lamps, lit(0, 4'b0100));
            check("ped_walk", walks, {6'b010101, wseq[i]});
            next_tick();
        end
        check("ped_yel", lamps, lit(0, 4'b0010));
        check("ped_yel_walk", walks, WALK_DEF);

        do_reset();
        pulse(4'b0100, 4'b0000, 4'b0000);
        next_tick();
        span("e_grn", lit(2, 4'b0100), 2);
        pulse(4'b0100, 4'b0000, 4'b0000);
        span("e_grn", lit(2, 4'b0100), 6);
        span("e_yel", lit(2, 4'b0010), 3);
        span("e_ar", ALL_RED, 2);
        check("e_again_phase", phase, 2);
        check("e_again_off", off_sign, 0);
        span("e2_grn", lit(2, 4'b0100), 8);
        span("e2_yel", lit(2, 4'b0010), 3);
        span("e2_ar", ALL_RED, 2);
        check("e2_idle_off", off_sign, 1);

        do_reset();
        pulse(4'b1000, 4'b0000, 4'b1000);
        next_tick();
        check("s_phase", phase, 3);
`ifdef LIGHT_SCHED_LEFT_ARROW_EN
        span("s_arrow", lit(3, 4'b1001), 3);
`endif
        span("s_grn", lit(3, 4'b0100), 8);
        span("s_yel", lit(3, 4'b0010), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_lamps", lamps, ALL_RED);
        check("arst_walk", walks, WALK_DEF);
        check("arst_phase", phase, 0);
        check("arst_off", off_sign, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
